count_snapshot_fifo: RTL and testbench
======================================

COUNT_SNAPSHOT_FIFO -- requirements
Module: count_snapshot_fifo

Interface
REQ-001 Parameter: DEPTH, 4, number of snapshot entries; power of two, minimum 2.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: cr_data_input  input  4  live value from the upstream 4-bit counter's cr_data_output.
REQ-005 Port: capture  input  1  snapshot request, sampled on the rising edge of clk.
REQ-006 Port: rd_ready  input  1  downstream consumer accepts the head entry.
REQ-007 Port: rd_valid  output  1  head entry available.
REQ-008 Port: rd_data  output  4  head entry counter value.
REQ-009 Port: level  output  clog2(DEPTH+1)  number of stored entries.
REQ-010 Port: full, empty  output  1 each  level==DEPTH, level==0.
REQ-011 Port: overflow  output  1  sticky flag: a capture was dropped.

Function
REQ-012 Push occurs when capture=1 and either (not full) or (full and a pop occurs in the same cycle).
REQ-013 Pop occurs when rd_valid=1 and rd_ready=1.
REQ-014 rd_valid SHALL equal not empty; rd_data SHALL show the head entry, and is don't-care while empty.
REQ-015 Capture-to-rd_valid latency SHALL be exactly 1 cycle; there is no combinational bypass from cr_data_input to rd_data.
REQ-016 Push on empty with rd_ready=1 SHALL NOT pop in the same cycle.
REQ-017 Push on full without pop: entry dropped, contents unchanged, overflow set to 1 next cycle.
REQ-018 Simultaneous push and pop SHALL leave level unchanged, whether full or partially filled.
REQ-019 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-020 level SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or go below 0.
REQ-021 overflow SHALL clear only on reset.
REQ-022 Entry order SHALL be strict FIFO.

Reset
REQ-023 While reset=1, asynchronously: pointers=0, level=0, empty=1, full=0, rd_valid=0, overflow=0, rd_data=4'b0000.
REQ-024 Reset asserted mid-operation SHALL discard all stored entries; no pop or push completes in the reset cycle.
REQ-025 The first push SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-026 Macro SNAPSHOT_WRAP_FLAG_EN defined: add output port rd_wrap (1 bit), stored per entry, equal to 1 if the counter wrapped since the previous accepted push, including the push cycle itself.
REQ-027 A wrap is detected when the registered previous cr_data_input equals 4'b1111 and the current value equals 4'b0000.
REQ-028 The wrap tracker SHALL clear on every accepted push and on reset, including when the push coincides with a wrap; a dropped push SHALL NOT clear it.
REQ-029 Macro undefined: no rd_wrap port, no tracker, and entry width of 4 bits.

Structure
REQ-030 Shared package cnt_pkg SHALL hold CNT_W=4, the default DEPTH, and the entry struct typedef (value plus optional wrap bit).
REQ-031 Storage SHALL be a sub-module snapshot_ram: a DEPTH x entry-width register array with one write port and one asynchronous read port, no reset on the array.
REQ-032 Pointer, level, flag and wrap logic SHALL reside in count_snapshot_fifo.

Verification
REQ-033 Reset, then capture at cr_data_input=4'b0011 -> next cycle rd_valid=1, rd_data=0011, level=1.
REQ-034 Capture 1,2,3,4 with rd_ready=0 and DEPTH=4 -> full=1; a 5th capture at value 5 -> overflow=1, data reads back 1,2,3,4.
REQ-035 While full, capture 9 with rd_ready=1 -> pops 1, level stays 4, tail=9.
REQ-036 Load 2 entries, assert reset mid-stream -> empty=1, level=0, overflow=0 immediately, no clk edge needed.
REQ-037 Macro on: input sequence 1110,1111,0000,0001 with capture on 0001 -> rd_wrap=1; the next capture without a wrap -> rd_wrap=0.
REQ-038 Capture on empty with rd_ready held at 1 -> entry visible for exactly 1 cycle, then empty=1.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared types and constants for the counter snapshot FIFO.
// SNAPSHOT_WRAP_FLAG_EN adds a per-entry counter-wrap bit to entry_t.
package cnt_pkg;

    localparam int CNT_W         = 4;
    localparam int DEPTH_DEFAULT = 4;

    typedef struct packed {
`ifdef SNAPSHOT_WRAP_FLAG_EN
        logic             wrap;
`endif
        logic [CNT_W-1:0] value;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

`ifdef SNAPSHOT_WRAP_FLAG_EN
    // A wrap is the counter stepping from all-ones to all-zeros between two samples.
    function automatic logic is_wrap(input logic [CNT_W-1:0] prev, input logic [CNT_W-1:0] cur);
        return (prev == {CNT_W{1'b1}}) && (cur == {CNT_W{1'b0}});
    endfunction
`endif

endpackage

// File: rtl/snapshot_ram.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read port.
// The array is deliberately not reset; validity is tracked by the FIFO pointers.
module snapshot_ram #(
    parameter int DEPTH = 4,
    parameter int W     = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/count_snapshot_fifo.sv
// FIFO of snapshots of an upstream 4-bit counter with sticky overflow flag.
// SNAPSHOT_WRAP_FLAG_EN adds rd_wrap: counter wrapped since the previous accepted push.
module count_snapshot_fifo
    import cnt_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CNT_W-1:0]           cr_data_input,
    input  logic                       capture,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [CNT_W-1:0]           rd_data,
`ifdef SNAPSHOT_WRAP_FLAG_EN
    output logic                       rd_wrap,
`endif
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic [LVL_W-1:0] level_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             overflow_r;
    logic             push_s;
    logic             pop_s;
    logic             we_s;
    entry_t           wr_entry_s;
    entry_t           rd_entry_s;

    // Pop only from a non-empty head, so a push into an empty FIFO is never popped the same cycle.
    assign pop_s  = ~empty_r & rd_ready;
    assign push_s = capture & (~full_r | pop_s);
    assign we_s   = push_s & ~reset;

`ifdef SNAPSHOT_WRAP_FLAG_EN
    logic [CNT_W-1:0] prev_r;
    logic             wrap_pend_r;
    logic             wrap_now_s;

    assign wrap_now_s = is_wrap(prev_r, cr_data_input);

    // Wrap tracker: cleared by any accepted push, set by a wrap otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_r      <= {CNT_W{1'b0}};
            wrap_pend_r <= 1'b0;
        end else begin
            prev_r <= cr_data_input;
            if (push_s) begin
                wrap_pend_r <= 1'b0;
            end else if (wrap_now_s) begin
                wrap_pend_r <= 1'b1;
            end
        end
    end
`endif

    // Assemble the entry to be written
    always_comb begin
        wr_entry_s       = '0;
        wr_entry_s.value = cr_data_input;
`ifdef SNAPSHOT_WRAP_FLAG_EN
        wr_entry_s.wrap  = wrap_pend_r | wrap_now_s;
`endif
    end

    snapshot_ram #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (we_s),
        .waddr (wr_ptr_r),
        .wdata (wr_entry_s),
        .raddr (rd_ptr_r),
        .rdata (rd_entry_s)
    );

    // Next occupancy; simultaneous push and pop leaves it unchanged
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_W'(1);
            2'b01:   level_nxt_s = level_r - LVL_W'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Pointers, occupancy and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            level_r    <= {LVL_W{1'b0}};
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            level_r <= level_nxt_s;
            full_r  <= (level_nxt_s == LVL_W'(DEPTH));
            empty_r <= (level_nxt_s == {LVL_W{1'b0}});
            if (capture & ~push_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign rd_valid = ~empty_r;
    assign level    = level_r;
    assign full     = full_r;
    assign empty    = empty_r;
    assign overflow = overflow_r;
    // The array is unreset, so mask the head while empty to keep rd_data at zero in reset.
    assign rd_data  = empty_r ? {CNT_W{1'b0}} : rd_entry_s.value;
`ifdef SNAPSHOT_WRAP_FLAG_EN
    assign rd_wrap  = ~empty_r & rd_entry_s.wrap;
`endif

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Self-checking bench for count_snapshot_fifo: directed scenarios plus random traffic
// against a queue-based reference model. Honors SNAPSHOT_WRAP_FLAG_EN when defined.
module tb_count_snapshot_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cr_data_input;
    logic       capture;
    logic       rd_ready;
    logic       rd_valid;
    logic [3:0] rd_data;
    logic [2:0] level;
    logic       full;
    logic       empty;
    logic       overflow;
`ifdef SNAPSHOT_WRAP_FLAG_EN
    logic       rd_wrap;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of {wrap, value}
    logic [4:0] q[$];
    logic       m_ovf;
    logic [3:0] m_prev;
    logic       m_pend;

    count_snapshot_fifo #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .cr_data_input (cr_data_input),
        .capture       (capture),
        .rd_ready      (rd_ready),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
`ifdef SNAPSHOT_WRAP_FLAG_EN
        .rd_wrap       (rd_wrap),
`endif
        .level         (level),
        .full          (full),
        .empty         (empty),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_ovf  = 1'b0;
        m_prev = 4'd0;
        m_pend = 1'b0;
    endtask

    task automatic model_step(input logic cap, input logic [3:0] val, input logic rdy);
        int  n;
        bit  pop;
        bit  push;
        bit  wnow;
        n    = q.size();
        pop  = (n > 0) && rdy;
        push = cap && ((n < DEPTH) || pop);
        wnow = (m_prev == 4'd15) && (val == 4'd0);
        if (pop) void'(q.pop_front());
        if (push) q.push_back({m_pend | wnow, val});
        if (cap && !push) m_ovf = 1'b1;
        if (push) m_pend = 1'b0;
        else if (wnow) m_pend = 1'b1;
        m_prev = val;
    endtask

    task automatic check_all();
        check("rd_valid", {31'd0, rd_valid}, {31'd0, q.size() != 0});
        check("level", {29'd0, level}, q.size());
        check("full", {31'd0, full}, {31'd0, q.size() == DEPTH});
        check("empty", {31'd0, empty}, {31'd0, q.size() == 0});
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        if (q.size() != 0) begin
            check("rd_data", {28'd0, rd_data}, {28'd0, q[0][3:0]});
`ifdef SNAPSHOT_WRAP_FLAG_EN
            check("rd_wrap", {31'd0, rd_wrap}, {31'd0, q[0][4]});
`endif
        end
    endtask

    // One clock: drive at negedge, model the edge, sample at next negedge
    task automatic cycle(input logic cap, input logic [3:0] val, input logic rdy);
        capture       = cap;
        cr_data_input = val;
        rd_ready      = rdy;
        model_step(cap, val, rdy);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    // Mid-cycle async reset: state must clear before any clock edge
    task automatic do_reset();
        reset   = 1'b1;
        capture = 1'b1;
        #1;
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_level", {29'd0, level}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_data", {28'd0, rd_data}, 32'd0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        check("rst_hold_level", {29'd0, level}, 32'd0);
        reset   = 1'b0;
        capture = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        capture       = 1'b0;
        rd_ready      = 1'b0;
        cr_data_input = 4'd0;
        model_clear();
        @(negedge clk);
        do_reset();

        // Capture on first edge after reset
        cycle(1'b1, 4'b0011, 1'b0);
        check("first_valid", {31'd0, rd_valid}, 32'd1);
        check("first_data", {28'd0, rd_data}, 32'd3);
        check("first_level", {29'd0, level}, 32'd1);

        // Fill, overflow, read back
        do_reset();
        for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 1'b0);
        check("fill_full", {31'd0, full}, 32'd1);
        cycle(1'b1, 4'd5, 1'b0);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check("ovf_level", {29'd0, level}, 32'd4);
        for (int i = 1; i <= 4; i++) begin
            check("readback", {28'd0, rd_data}, i);
            cycle(1'b0, 4'd0, 1'b1);
        end
        check("drained", {31'd0, empty}, 32'd1);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Push+pop while full
        for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 1'b0);
        cycle(1'b1, 4'd9, 1'b1);
        check("pp_level", {29'd0, level}, 32'd4);
        check("pp_head", {28'd0, rd_data}, 32'd2);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, 1'b1);
        check("pp_tail", {28'd0, rd_data}, 32'd9);
        cycle(1'b0, 4'd0, 1'b1);

        // Mid-stream reset with entries stored
        cycle(1'b1, 4'd6, 1'b0);
        cycle(1'b1, 4'd7, 1'b0);
        do_reset();

        // Capture on empty with rd_ready held high: visible exactly one cycle
        cycle(1'b1, 4'd10, 1'b1);
        check("pass_valid", {31'd0, rd_valid}, 32'd1);
        check("pass_data", {28'd0, rd_data}, 32'd10);
        cycle(1'b0, 4'd11, 1'b1);
        check("pass_empty", {31'd0, empty}, 32'd1);

`ifdef SNAPSHOT_WRAP_FLAG_EN
        do_reset();
        cycle(1'b0, 4'b1110, 1'b0);
        cycle(1'b0, 4'b1111, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b1, 4'b0001, 1'b0);
        check("wrap_set", {31'd0, rd_wrap}, 32'd1);
        cycle(1'b1, 4'b0010, 1'b1);
        check("wrap_clr", {31'd0, rd_wrap}, 32'd0);
        cycle(1'b0, 4'b0010, 1'b1);
`endif

        // Random traffic against the model
        begin
            logic [3:0] cnt;
            int         bias;
            cnt = 4'd0;
            for (int c = 0; c < 3000; c++) begin
                if ($urandom_range(0, 249) == 0) begin
                    do_reset();
                end
                if ($urandom_range(0, 7) == 0) cnt = 4'($urandom_range(0, 15));
                else if ($urandom_range(0, 3) != 0) cnt = cnt + 4'd1;
                bias = (c / 200) % 3;
                cycle(1'($urandom_range(0, 1)), cnt,
                      (bias == 0) ? 1'($urandom_range(0, 3) == 0) :
                      (bias == 1) ? 1'($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
